// File: rtl/srt2_byte_divider.sv
// Byte-serial 32/32 divider: eight pushed operand bytes feed a radix-2 SRT core,
// and the corrected remainder and quotient are streamed back one byte per cycle.
module srt2_byte_divider #(
  parameter int DATA_WIDTH       = 65,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = 3,
  parameter int WIDTH            = 32,
  parameter int EXPWIDTH         = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in_in,
  input  logic       push_in,
  input  logic       sign,
  input  logic       select,
  output logic [7:0] data_out_out,
  output logic       pull_out,
  output logic       sign_out
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, NORM, BUSY, CORR, OUT} state_t;

  state_t                      state_q, state_d;
  logic [LOG_BUFFER_DEPTH-1:0] cnt_q, cnt_d;
  logic [SHW-1:0]              iter_q, iter_d;
  logic [SHW-1:0]              shift_q, shift_d;
  logic [7:0]                  inBuf_q [2*BUFFER_DEPTH];
  logic                        signMode_q, signMode_d;
  logic                        signOut_q, signOut_d;
  logic                        divZero_q, divZero_d;
  logic [DATA_WIDTH-1:0]       work_q, work_d;
  logic [WIDTH-1:0]            dn_q, dn_d;
  logic [WIDTH-1:0]            qPos_q, qPos_d;
  logic [WIDTH-1:0]            qNeg_q, qNeg_d;
  logic [2*WIDTH-1:0]          res_q, res_d;

  logic [WIDTH-1:0]   zWord, dWord, zMag, dMag;
  logic [SHW-1:0]     lzc;
  logic               lzFound;
  logic [2*WIDTH-1:0] xWide;
  logic [WIDTH:0]     pCur;
  logic [WIDTH+1:0]   p2, dnExt, pNext;
  logic [2:0]         pTop;
  logic               qPlus, qMinus;
  logic [WIDTH:0]     rSum;
  logic [WIDTH-1:0]   qRaw, qFix, rNorm, rMag, qOut, rOut;
  logic               unused_ok;

  assign unused_ok = &{1'b0, select, EXPWIDTH[0]};

  always_comb begin
    zWord = '0;
    dWord = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      zWord[WIDTH-1-8*i -: 8] = inBuf_q[i];
      dWord[WIDTH-1-8*i -: 8] = inBuf_q[i+BUFFER_DEPTH];
    end
  end

  assign zMag = signMode_q ? {1'b0, zWord[WIDTH-2:0]} : zWord;
  assign dMag = signMode_q ? {1'b0, dWord[WIDTH-2:0]} : dWord;

  // Normalising the divisor to bit 31 keeps the SRT digit selection to three top bits.
  always_comb begin
    lzc     = '0;
    lzFound = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!lzFound && dMag[i]) begin
        lzc     = SHW'(WIDTH - 1 - i);
        lzFound = 1'b1;
      end
    end
  end

  assign xWide = {{WIDTH{1'b0}}, zMag} << lzc;

  assign pCur   = work_q[DATA_WIDTH-1:WIDTH];
  assign p2     = {pCur, work_q[WIDTH-1]};
  assign pTop   = p2[WIDTH+1:WIDTH-1];
  assign qPlus  = !pTop[2] && (pTop != 3'b000);
  assign qMinus = pTop[2] && (pTop != 3'b111);
  assign dnExt  = {2'b00, dn_q};
  assign pNext  = qPlus ? (p2 - dnExt) : (qMinus ? (p2 + dnExt) : p2);

  // Collapse the redundant digits and fold a negative final remainder back into range.
  always_comb begin
    qRaw  = qPos_q - qNeg_q;
    rSum  = pCur + {1'b0, dn_q};
    qFix  = qRaw;
    rNorm = pCur[WIDTH-1:0];
    if (pCur[WIDTH]) begin
      qFix  = qRaw - 1'b1;
      rNorm = rSum[WIDTH-1:0];
    end
    rMag = rNorm >> shift_q;
    if (divZero_q) begin
      qFix = '1;
      rMag = zMag;
    end
    qOut = qFix;
    rOut = rMag;
    if (signMode_q) begin
      qOut = {zWord[WIDTH-1] ^ dWord[WIDTH-1], qFix[WIDTH-2:0]};
      rOut = {zWord[WIDTH-1], rMag[WIDTH-2:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iter_d     = iter_q;
    shift_d    = shift_q;
    signMode_d = signMode_q;
    signOut_d  = signOut_q;
    divZero_d  = divZero_q;
    work_d     = work_q;
    dn_d       = dn_q;
    qPos_d     = qPos_q;
    qNeg_d     = qNeg_q;
    res_d      = res_q;
    unique case (state_q)
      IDLE: begin
        if (push_in) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            signMode_d = sign;
            state_d    = NORM;
          end
        end
      end
      NORM: begin
        work_d    = {1'b0, xWide};
        dn_d      = dMag << lzc;
        shift_d   = lzc;
        divZero_d = (dMag == '0);
        iter_d    = '0;
        qPos_d    = '0;
        qNeg_d    = '0;
        state_d   = (dMag == '0) ? CORR : BUSY;
      end
      BUSY: begin
        work_d = {pNext[WIDTH:0], work_q[WIDTH-2:0], 1'b0};
        qPos_d = {qPos_q[WIDTH-2:0], qPlus};
        qNeg_d = {qNeg_q[WIDTH-2:0], qMinus};
        iter_d = iter_q + 1'b1;
        if (iter_q == '1) state_d = CORR;
      end
      CORR: begin
        res_d     = {qOut, rOut};
        signOut_d = signMode_q;
        cnt_d     = '0;
        state_d   = OUT;
      end
      OUT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      iter_q     <= '0;
      shift_q    <= '0;
      signMode_q <= 1'b0;
      signOut_q  <= 1'b0;
      divZero_q  <= 1'b0;
      work_q     <= '0;
      dn_q       <= '0;
      qPos_q     <= '0;
      qNeg_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      shift_q    <= shift_d;
      signMode_q <= signMode_d;
      signOut_q  <= signOut_d;
      divZero_q  <= divZero_d;
      work_q     <= work_d;
      dn_q       <= dn_d;
      qPos_q     <= qPos_d;
      qNeg_q     <= qNeg_d;
      res_q      <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && push_in) inBuf_q[cnt_q] <= data_in_in;
  end

  assign data_out_out = (state_q == OUT) ? res_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign pull_out     = (state_q == OUT) && (cnt_q == '0);
  assign sign_out     = signOut_q;

endmodule

// File: tb/tb_srt2_byte_divider.sv
// Self-checking bench for srt2_byte_divider: directed vector table, reset/busy
// corner sequences and randomized transactions against an arithmetic reference.
module tb_srt2_byte_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in_in = 8'h00;
  logic       push_in = 1'b0;
  logic       sign = 1'b0;
  logic       select = 1'b0;
  logic [7:0] data_out_out;
  logic       pull_out;
  logic       sign_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] z;
    logic [31:0] d;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [9];

  srt2_byte_divider dut (
    .clk(clk), .rst_n(rst_n), .data_in_in(data_in_in), .push_in(push_in),
    .sign(sign), .select(select), .data_out_out(data_out_out),
    .pull_out(pull_out), .sign_out(sign_out)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain division on the magnitudes, signs attached afterwards.
  function automatic logic [63:0] refDiv(input logic [31:0] z, input logic [31:0] d, input logic sgn);
    logic [31:0] zm, dm, qm, rm, q, r;
    zm = sgn ? {1'b0, z[30:0]} : z;
    dm = sgn ? {1'b0, d[30:0]} : d;
    if (dm == 0) begin
      qm = 32'hFFFFFFFF;
      rm = zm;
    end else begin
      qm = zm / dm;
      rm = zm % dm;
    end
    q = qm;
    r = rm;
    if (sgn) begin
      q = {z[31] ^ d[31], qm[30:0]};
      r = {z[31], rm[30:0]};
    end
    return {q, r};
  endfunction

  task automatic applyStimulus(input logic [31:0] z, input logic [31:0] d, input logic sgn, input int nBytes);
    logic [63:0] w;
    w = {z, d};
    for (int i = 0; i < nBytes; i++) begin
      @(negedge clk);
      push_in    = 1'b1;
      data_in_in = w[63-8*i -: 8];
      sign       = sgn;
      select     = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    push_in    = 1'b0;
    data_in_in = 8'h00;
    sign       = 1'b0;
    select     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expQ, input logic [31:0] expR, input logic expSign);
    int waitCyc;
    logic [63:0] got;
    logic [7:0] pulls;
    waitCyc = 0;
    while (!pull_out && waitCyc < 60) begin
      @(negedge clk);
      waitCyc++;
    end
    compare({name, " pull_seen"}, {63'd0, pull_out}, 64'd1);
    if (!pull_out) return;
    got = '0;
    pulls = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      got[8*i +: 8] = data_out_out;
      pulls[i] = pull_out;
    end
    compare({name, " R"}, {32'd0, got[31:0]}, {32'd0, expR});
    compare({name, " Q"}, {32'd0, got[63:32]}, {32'd0, expQ});
    compare({name, " pull_pattern"}, {56'd0, pulls}, 64'h01);
    compare({name, " sign_out"}, {63'd0, sign_out}, {63'd0, expSign});
    @(negedge clk);
    compare({name, " idle_data"}, {56'd0, data_out_out}, 64'd0);
  endtask

  task automatic expectNoPull(input string name, input int cycles);
    int pulls;
    pulls = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pull_out) pulls++;
    end
    compare({name, " extra_pulls"}, 64'(pulls), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] z, d;
    logic        sg;

    vecs[0] = '{32'h00000064, 32'h00000007, 1'b0, 32'h0000000E, 32'h00000002};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000005, 1'b0, 32'h33333333, 32'h00000000};
    vecs[2] = '{32'h12345678, 32'h00010000, 1'b0, 32'h00001234, 32'h00005678};
    vecs[3] = '{32'h80000064, 32'h00000007, 1'b1, 32'h8000000E, 32'h80000002};
    vecs[4] = '{32'h00000005, 32'h80000009, 1'b1, 32'h80000000, 32'h00000005};
    vecs[5] = '{32'h00001234, 32'h00000000, 1'b0, 32'hFFFFFFFF, 32'h00001234};
    vecs[6] = '{32'h80000010, 32'h80000000, 1'b1, 32'h7FFFFFFF, 32'h80000010};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFF, 32'h00000000};
    vecs[8] = '{32'h00000007, 32'h00000064, 1'b0, 32'h00000000, 32'h00000007};

    repeat (3) @(negedge clk);
    compare("reset data_out", {56'd0, data_out_out}, 64'd0);
    compare("reset pull_out", {63'd0, pull_out}, 64'd0);
    compare("reset sign_out", {63'd0, sign_out}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].z, vecs[i].d, vecs[i].sgn, 8);
      checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].sgn);
      repeat (5) @(negedge clk);
    end

    applyStimulus(32'hDEADBEEF, 32'h55000000, 1'b1, 5);
    rst_n = 1'b0;
    @(negedge clk);
    compare("abort sign_out", {63'd0, sign_out}, 64'd0);
    rst_n = 1'b1;
    applyStimulus(32'h00000064, 32'h00000007, 1'b0, 8);
    checkOutput("abort_then_t1", 32'h0000000E, 32'h00000002, 1'b0);
    expectNoPull("abort_then_t1", 80);

    applyStimulus(32'h12345678, 32'h00010000, 1'b0, 8);
    applyStimulus(32'hA5A5A5A5, 32'h00000003, 1'b1, 8);
    checkOutput("busy_push", 32'h00001234, 32'h00005678, 1'b0);
    expectNoPull("busy_push", 100);

    for (int n = 0; n < 80; n++) begin
      z  = $urandom;
      d  = $urandom >> (8 * $urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      exp = refDiv(z, d, sg);
      applyStimulus(z, d, sg, 8);
      checkOutput($sformatf("rand%0d z=%h d=%h s=%0d", n, z, d, sg), exp[63:32], exp[31:0], sg);
      repeat (100) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
